fifo_thresh: RTL and testbench
==============================

// Module: fifo_thresh
// PURPOSE
//   Parametrised successor of the single-clock bus FIFO: first-word-fall-through, per-DATA_WIDTH
//   storage with a selectable strobe mode, occupancy count and programmable almost-full/empty flags.
//   Sits between register-mapped peripherals (UART, SPI) and the CPU bus, or between two cores.
// PARAMETERS
//   DATA_WIDTH  8   word width in bits
//   DEPTH       16  entries; power of two, >= 2; ADDR_WIDTH = $clog2(DEPTH)
//   EDGE_TRIG   1   1: wr_en/rd_en act on rising edge only (bus-register use); 0: act every cycle high
// PORTS
//   clk          in   1             single clock, all logic on posedge
//   rst_n        in   1             reset, synchronous, active-low
//   wr_en        in   1             write strobe (see EDGE_TRIG)
//   rd_en        in   1             read/pop strobe (see EDGE_TRIG)
//   din          in   DATA_WIDTH    write data, sampled with an accepted write
//   af_thresh    in   ADDR_WIDTH+1  almost-full threshold (level >= af_thresh)
//   ae_thresh    in   ADDR_WIDTH+1  almost-empty threshold (level <= ae_thresh)
//   dout         out  DATA_WIDTH    head word, combinational; all zeros when empty
//   empty        out  1             level == 0
//   full         out  1             level == DEPTH
//   almost_full  out  1             level >= af_thresh
//   almost_empty out  1             level <= ae_thresh
//   level        out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
// BEHAVIOUR
//   - Strobes: EDGE_TRIG=1 -> wr_stb = wr_en & ~wr_en_q; rd_stb = rd_en & ~rd_en_q (one pulse per
//     high phase). EDGE_TRIG=0 -> wr_stb = wr_en, rd_stb = rd_en.
//   - Accept: wr_ok = wr_stb & ~full; rd_ok = rd_stb & ~empty. Both decided on pre-edge flags.
//   - wr_ok: mem[wr_ptr[ADDR_WIDTH-1:0]] <= din, wr_ptr++. rd_ok: rd_ptr++. Pointers ADDR_WIDTH+1
//     bits, wrap naturally; full = MSBs differ & low bits equal; empty = pointers equal.
//   - level register: +1 on wr_ok only, -1 on rd_ok only, unchanged on both/neither.
//   - Simultaneous wr+rd: when full, write refused, read accepted (level DEPTH-1); when empty, read
//     refused, write accepted (level 1); otherwise both accepted, level unchanged.
//   - Latency: written word visible on dout the cycle after the accepting edge; pop advances dout
//     the cycle after. No other latency.
//   - Status flags combinational from level/pointers; thresholds may change any cycle, take effect
//     immediately. af_thresh=0 -> almost_full constant 1; ae_thresh>=DEPTH -> almost_empty const 1.
//   - Reset (rst_n low at posedge): pointers, level, wr_en_q, rd_en_q <= 0; mem not cleared.
//     After reset: empty=1, full=0, level=0, dout=0, almost_empty=1, almost_full=(af_thresh==0).
//     Reset mid-operation discards contents; strobe held high across release counts as an edge
//     on the first active cycle (EDGE_TRIG=1).
// CONFIGURATION
//   FIFO_THRESH_ERR_EN defined: adds ports err_clr (in,1), overflow (out,1), underflow (out,1).
//     overflow sets on wr_stb & full, underflow on rd_stb & empty; both sticky until err_clr; set
//     wins over err_clr same cycle; both 0 after reset.
//   Not defined: ports and flag logic absent; refused strobes silently dropped.
// STRUCTURE
//   fifo_pkg.vh: ADDR_WIDTH calc helper, EDGE_TRIG mode localparams (STB_EDGE=1, STB_LEVEL=0).
//   Sub-module fifo_strobe_gen: one instance per strobe; EDGE_TRIG param, registered previous-value
//     and pulse output. Storage, pointers, level and flags stay in fifo_thresh.
// TESTING
//   1 Reset, DEPTH=16, EDGE_TRIG=1: write 0x11..0x1F,0x10 (16 edges) -> full=1, level=16;
//     17th edge with din=0xAA -> not stored, level 16 (overflow=1 if FIFO_THRESH_ERR_EN).
//   2 EDGE_TRIG=1, hold rd_en high 5 cycles on 3-entry FIFO -> exactly one pop, level 2.
//   3 EDGE_TRIG=0, rd_en+wr_en high 4 cycles at level 5 -> level stays 5, dout order preserved.
//   4 Full FIFO, wr+rd same cycle -> write refused, level 15; empty FIFO, wr+rd din=0x5A -> level 1,
//     dout=0x5A next cycle.
//   5 af_thresh=12, ae_thresh=3: fill 0..16 -> almost_empty high for level<=3, almost_full from
//     level 12; change af_thresh to 4 at level 8 -> almost_full=1 same cycle.
//   6 rst_n low mid-stream at level 9 -> next cycle empty=1, level=0, dout=0, pointers wrap-free.

Source files
------------

// File: rtl/fifo_thresh_pkg.sv
// Shared definitions for fifo_thresh: strobe mode encodings, address width helper, flag bundle.
// Optional error flags are enabled by defining FIFO_THRESH_ERR_EN.
package fifo_thresh_pkg;

    localparam int unsigned STB_LEVEL = 0;
    localparam int unsigned STB_EDGE  = 1;

    // Depths below 2 still need a one-bit index.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth < 2) ? 1 : unsigned'($clog2(depth));
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/fifo_thresh_strobe_gen.sv
// Strobe qualifier: passes the enable straight through (level mode) or emits a single-cycle
// pulse on each rising edge (edge mode) using a registered copy of the previous enable.
module fifo_thresh_strobe_gen
    import fifo_thresh_pkg::*;
#(
    parameter int unsigned EDGE_TRIG = STB_EDGE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic stb
);

    logic en_q;
    logic en_d;

    always_comb begin
        en_d = en;
    end

    // Cleared in reset so an enable held high across release reads as a fresh edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_d;
        end
    end

    always_comb begin
        if (EDGE_TRIG == STB_LEVEL) begin
            stb = en;
        end else begin
            stb = en & ~en_q;
        end
    end

endmodule

// File: rtl/fifo_thresh.sv
// Single-clock first-word-fall-through FIFO with occupancy count and programmable almost flags.
// Defining FIFO_THRESH_ERR_EN adds sticky overflow/underflow flags with an err_clr input.
module fifo_thresh
    import fifo_thresh_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned EDGE_TRIG  = STB_EDGE,
    localparam int unsigned ADDR_WIDTH = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
`ifdef FIFO_THRESH_ERR_EN
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [ADDR_WIDTH:0]   level
);

    localparam logic [ADDR_WIDTH:0] CntOne = 1;

    logic                  wr_stb;
    logic                  rd_stb;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    fifo_flags_t           flags;

    fifo_thresh_strobe_gen #(
        .EDGE_TRIG (EDGE_TRIG)
    ) u_wr_stb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wr_en),
        .stb   (wr_stb)
    );

    fifo_thresh_strobe_gen #(
        .EDGE_TRIG (EDGE_TRIG)
    ) u_rd_stb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rd_en),
        .stb   (rd_stb)
    );

    // Extra pointer MSB distinguishes full from empty when the index bits coincide.
    always_comb begin
        flags              = '0;
        flags.empty        = (wr_ptr_q == rd_ptr_q);
        flags.full         = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                             (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
        flags.almost_full  = (level_q >= af_thresh);
        flags.almost_empty = (level_q <= ae_thresh);
    end

    always_comb begin
        wr_ok = wr_stb & ~flags.full;
        rd_ok = rd_stb & ~flags.empty;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + CntOne;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + CntOne;
        end
        unique case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + CntOne;
            2'b01:   level_d = level_q - CntOne;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; dout is masked while empty so stale words never show.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= din;
        end
    end

    always_comb begin
        dout         = flags.empty ? '0 : mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        empty        = flags.empty;
        full         = flags.full;
        almost_full  = flags.almost_full;
        almost_empty = flags.almost_empty;
        level        = level_q;
    end

`ifdef FIFO_THRESH_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new refusal outranks a clear in the same cycle.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_stb && flags.full) begin
            overflow_d = 1'b1;
        end
        if (rd_stb && flags.empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        overflow  = overflow_q;
        underflow = underflow_q;
    end
`endif

endmodule

// File: tb/tb_fifo_thresh.sv
// Bench for fifo_thresh: an edge-triggered and a level-triggered instance share stimulus and are
// each checked every cycle against a queue-based model, plus directed literal checks.
module tb_fifo_thresh;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] din;
    logic [AW:0]   af_thresh;
    logic [AW:0]   ae_thresh;

    logic [DW-1:0] dout_x [2];
    logic          empty_x [2];
    logic          full_x [2];
    logic          af_x [2];
    logic          ae_x [2];
    logic [AW:0]   level_x [2];
`ifdef FIFO_THRESH_ERR_EN
    logic          err_clr;
    logic          ovf_x [2];
    logic          unf_x [2];
    logic          m_ovf [2];
    logic          m_unf [2];
`endif

    int n_tests;
    int n_fail;

    // Reference state: index 0 models the edge instance, index 1 the level instance.
    logic [DW-1:0] mq [2][$];
    logic          prev_wr [2];
    logic          prev_rd [2];
    logic          model_valid;

    fifo_thresh #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .EDGE_TRIG(1)) dut_e (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .din          (din),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .dout         (dout_x[0]),
        .empty        (empty_x[0]),
        .full         (full_x[0]),
        .almost_full  (af_x[0]),
        .almost_empty (ae_x[0]),
`ifdef FIFO_THRESH_ERR_EN
        .err_clr      (err_clr),
        .overflow     (ovf_x[0]),
        .underflow    (unf_x[0]),
`endif
        .level        (level_x[0])
    );

    fifo_thresh #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .EDGE_TRIG(0)) dut_l (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .din          (din),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .dout         (dout_x[1]),
        .empty        (empty_x[1]),
        .full         (full_x[1]),
        .almost_full  (af_x[1]),
        .almost_empty (ae_x[1]),
`ifdef FIFO_THRESH_ERR_EN
        .err_clr      (err_clr),
        .overflow     (ovf_x[1]),
        .underflow    (unf_x[1]),
`endif
        .level        (level_x[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on every active edge using the same pre-edge inputs the DUTs see.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                mq[k].delete();
                prev_wr[k] = 1'b0;
                prev_rd[k] = 1'b0;
`ifdef FIFO_THRESH_ERR_EN
                m_ovf[k] = 1'b0;
                m_unf[k] = 1'b0;
`endif
            end
            model_valid = 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic ws, rs, was_full, was_empty;
                ws = (k == 0) ? (wr_en && !prev_wr[k]) : wr_en;
                rs = (k == 0) ? (rd_en && !prev_rd[k]) : rd_en;
                was_full  = (mq[k].size() == DEPTH);
                was_empty = (mq[k].size() == 0);
                if (rs && !was_empty) void'(mq[k].pop_front());
                if (ws && !was_full) mq[k].push_back(din);
`ifdef FIFO_THRESH_ERR_EN
                if (err_clr) begin
                    m_ovf[k] = 1'b0;
                    m_unf[k] = 1'b0;
                end
                if (ws && was_full) m_ovf[k] = 1'b1;
                if (rs && was_empty) m_unf[k] = 1'b1;
`endif
                prev_wr[k] = wr_en;
                prev_rd[k] = rd_en;
            end
        end
    end

    // Single compare process, mid-cycle, once the model has seen a reset.
    always @(negedge clk) begin
        if (model_valid) begin
            for (int k = 0; k < 2; k++) begin
                int sz;
                int head;
                string tag;
                tag  = (k == 0) ? "edge" : "lvl";
                sz   = mq[k].size();
                head = (sz > 0) ? int'(mq[k][0]) : 0;
                chk({tag, ".dout"}, int'(dout_x[k]), head);
                chk({tag, ".level"}, int'(level_x[k]), sz);
                chk({tag, ".empty"}, int'(empty_x[k]), int'(sz == 0));
                chk({tag, ".full"}, int'(full_x[k]), int'(sz == DEPTH));
                chk({tag, ".almost_full"}, int'(af_x[k]), int'(sz >= int'(af_thresh)));
                chk({tag, ".almost_empty"}, int'(ae_x[k]), int'(sz <= int'(ae_thresh)));
`ifdef FIFO_THRESH_ERR_EN
                chk({tag, ".overflow"}, int'(ovf_x[k]), int'(m_ovf[k]));
                chk({tag, ".underflow"}, int'(unf_x[k]), int'(m_unf[k]));
`endif
            end
        end
    end

    // Inputs change shortly after the active edge and act on the following one.
    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
        @(posedge clk);
        #2;
        wr_en = w;
        rd_en = r;
        din   = d;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic pulse_wr(input logic [DW-1:0] d);
        cyc(1'b1, 1'b0, d);
        cyc(1'b0, 1'b0, d);
    endtask

    task automatic pulse_rd();
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        model_valid = 1'b0;
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        din         = '0;
        af_thresh   = 5'd0;
        ae_thresh   = 5'd3;
`ifdef FIFO_THRESH_ERR_EN
        err_clr     = 1'b0;
`endif

        // Reset state, with af_thresh=0 forcing almost_full.
        do_reset();
        @(negedge clk);
        chk("rst.empty", int'(empty_x[0]), 1);
        chk("rst.full", int'(full_x[0]), 0);
        chk("rst.level", int'(level_x[0]), 0);
        chk("rst.dout", int'(dout_x[0]), 0);
        chk("rst.almost_empty", int'(ae_x[0]), 1);
        chk("rst.almost_full_af0", int'(af_x[0]), 1);
        #1 af_thresh = 5'd12;
        #1 chk("rst.almost_full_af12", int'(af_x[0]), 0);

        // Fill 0x11..0x1F,0x10; at level 8 a lowered af_thresh takes effect immediately.
        for (int i = 0; i < 16; i++) begin
            pulse_wr((i == 15) ? 8'h10 : 8'(8'h11 + i));
            if (i == 7) begin
                @(negedge clk);
                chk("thr.af_at8", int'(af_x[0]), 0);
                #1 af_thresh = 5'd4;
                #1 chk("thr.af_lowered", int'(af_x[0]), 1);
                #1 af_thresh = 5'd12;
            end
        end
        @(negedge clk);
        chk("fill.full", int'(full_x[0]), 1);
        chk("fill.level", int'(level_x[0]), 16);
        pulse_wr(8'hAA);
        @(negedge clk);
        chk("ovf.level", int'(level_x[0]), 16);
        chk("ovf.dout", int'(dout_x[0]), 8'h11);
`ifdef FIFO_THRESH_ERR_EN
        chk("ovf.flag", int'(ovf_x[0]), 1);
`endif

        // Full: simultaneous wr+rd refuses the write, accepts the read.
        cyc(1'b1, 1'b1, 8'hBB);
        cyc(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("fullwr.level", int'(level_x[0]), 15);
        chk("fullwr.dout", int'(dout_x[0]), 8'h12);

        // Drain to three entries, then hold rd_en for five cycles.
        for (int i = 0; i < 12; i++) pulse_rd();
        @(negedge clk);
        chk("drain.level", int'(level_x[0]), 3);
        chk("drain.dout", int'(dout_x[0]), 8'h1E);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("hold.edge_level", int'(level_x[0]), 2);
        chk("hold.edge_dout", int'(dout_x[0]), 8'h1F);
        chk("hold.lvl_empty", int'(empty_x[1]), 1);

        // Level 5, then wr+rd held four cycles.
        do_reset();
        for (int i = 0; i < 5; i++) pulse_wr(8'(8'h30 + i));
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'(8'h40 + i));
        cyc(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("wr_rd.lvl_level", int'(level_x[1]), 5);
        chk("wr_rd.lvl_dout", int'(dout_x[1]), 8'h34);
        chk("wr_rd.edge_level", int'(level_x[0]), 5);
        chk("wr_rd.edge_dout", int'(dout_x[0]), 8'h31);

        // Empty: simultaneous wr+rd accepts the write only.
        do_reset();
        cyc(1'b1, 1'b1, 8'h5A);
        cyc(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("empty_wr_rd.level", int'(level_x[0]), 1);
        chk("empty_wr_rd.dout", int'(dout_x[0]), 8'h5A);
`ifdef FIFO_THRESH_ERR_EN
        chk("empty_wr_rd.underflow", int'(unf_x[0]), 1);
`endif

        // Reset mid-stream at level 9.
        for (int i = 0; i < 8; i++) pulse_wr(8'(8'h60 + i));
        do_reset();
        @(negedge clk);
        chk("midrst.empty", int'(empty_x[0]), 1);
        chk("midrst.level", int'(level_x[0]), 0);
        chk("midrst.dout", int'(dout_x[0]), 0);

        // Write strobe held high across reset release counts as an edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        wr_en = 1'b1;
        din   = 8'h77;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("relhold.level", int'(level_x[0]), 1);
        chk("relhold.dout", int'(dout_x[0]), 8'h77);

        // Random traffic with shifting write/read bias.
        for (int c = 0; c < 4000; c++) begin
            int pw;
            pw = ((c / 250) % 2 == 0) ? 75 : 30;
            if (c % 37 == 0) begin
                af_thresh = 5'($urandom_range(18));
                ae_thresh = 5'($urandom_range(18));
            end
`ifdef FIFO_THRESH_ERR_EN
            err_clr = ($urandom_range(99) < 5);
`endif
            if ($urandom_range(999) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(99) < pw, $urandom_range(99) < (105 - pw),
                    8'($urandom));
            end
        end
        cyc(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
